// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and helpers for the instruction fetch unit.
package instr_fetch_unit_pkg;

    localparam int unsigned INSTR_W        = 16;
    localparam int unsigned OPCODE_W       = 5;
    localparam int unsigned ADDR_W_DEFAULT = 16;

    localparam logic [OPCODE_W-1:0]       HALT_OPCODE_DEFAULT = 5'b00000;
    localparam logic [ADDR_W_DEFAULT-1:0] RESET_PC_DEFAULT    = 16'h0000;

    // True when the instruction word carries the halt opcode in its top field.
    function automatic logic is_halt(input logic [INSTR_W-1:0] word,
                                     input logic [OPCODE_W-1:0] halt_op);
        return word[INSTR_W-1 -: OPCODE_W] == halt_op;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small synchronous prefetch FIFO with flush.
// Ports: clk, rst (async active-low), flush (empties FIFO, overrides push/pop),
//        push/push_data, pop, head (entry at read pointer), full, empty.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Storage, pointers and occupancy; a push into a full FIFO is only legal
    // alongside a pop, in which case it reuses the slot being vacated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the single-cycle instruction memory from the
// fetch PC, buffers returned words in a prefetch FIFO, and hands them to decode
// over valid/ready. Supports redirect-with-flush and stops fetching on HALT.
// Ports: clk, rst (async active-low); imem_addr/imem_en/imem_wr/imem_data_in to
//        memory, imem_data from memory; instr/instr_pc/instr_valid/instr_ready to
//        decode; redirect_valid/redirect_pc; halted status.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned               ADDR_WIDTH  = ADDR_W_DEFAULT,
    parameter logic [ADDR_WIDTH-1:0]     RESET_PC    = ADDR_WIDTH'(RESET_PC_DEFAULT),
    parameter int unsigned               DEPTH       = 2,
    parameter logic [OPCODE_W-1:0]       HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_en,
    output logic                  imem_wr,
    output logic [INSTR_W-1:0]    imem_data_in,
    input  logic [INSTR_W-1:0]    imem_data,
    output logic [INSTR_W-1:0]    instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  halted
);

    localparam int unsigned ENTRY_W = INSTR_W + ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic [ENTRY_W-1:0]    head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  fetch;

    assign pop             = instr_valid & instr_ready;
    // A slot frees up this cycle if the head is being consumed, so a full FIFO
    // can still accept the next word and sustain one instruction per cycle.
    assign fetch           = rst & ~redirect_valid & ~halted & (~fifo_full | pop);
    assign redirect_target = redirect_pc & ~ADDR_WIDTH'(1);

    assign imem_en      = fetch;
    assign imem_addr    = fetch_pc;
    assign imem_wr      = 1'b0;
    assign imem_data_in = '0;

    assign instr_valid = ~fifo_empty;
    assign instr       = head[ENTRY_W-1 -: INSTR_W];
    assign instr_pc    = head[ADDR_WIDTH-1:0];

    // Fetch PC and halt flag; redirect wins over everything and also un-halts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            halted   <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
            halted   <= 1'b0;
        end else if (fetch) begin
            fetch_pc <= fetch_pc + ADDR_WIDTH'(2);
            if (is_halt(imem_data, HALT_OPCODE)) begin
                halted <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (fetch),
        .push_data ({imem_data, fetch_pc}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory array plus a queue-based reference model.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic        imem_en;
    logic        imem_wr;
    logic [15:0] imem_data_in;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halted;

    logic [15:0] mem [0:32767];

    typedef struct {
        logic [15:0] word;
        logic [15:0] pc;
    } entry_t;

    entry_t      q[$];
    logic [15:0] m_pc;
    bit          m_halted;
    int          n_cmp = 0;
    int          n_err = 0;
    int          acc8  = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[15:1]];

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_en        (imem_en),
        .imem_wr        (imem_wr),
        .imem_data_in   (imem_data_in),
        .imem_data      (imem_data),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc     = 16'h0000;
        m_halted = 1'b0;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic cycle();
        bit     pop;
        bit     fet;
        entry_t e;
        @(negedge clk);
        pop = (q.size() > 0) && instr_ready;
        fet = !redirect_valid && !m_halted && (q.size() < DEPTH || pop);
        chk("imem_en", 32'(imem_en), 32'(fet));
        chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("imem_wr", 32'(imem_wr), 32'd0);
        chk("imem_data_in", 32'(imem_data_in), 32'd0);
        chk("instr_valid", 32'(instr_valid), 32'(q.size() > 0));
        chk("halted", 32'(halted), 32'(m_halted));
        if (q.size() > 0) begin
            chk("instr", 32'(instr), 32'(q[0].word));
            chk("instr_pc", 32'(instr_pc), 32'(q[0].pc));
        end
        if (imem_en && imem_addr == 16'h0008) acc8++;
        if (redirect_valid) begin
            q.delete();
            m_pc     = redirect_pc & 16'hFFFE;
            m_halted = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (fet) begin
                e.word = mem[m_pc >> 1];
                e.pc   = m_pc;
                q.push_back(e);
                if (e.word[15:11] == 5'b00000) m_halted = 1'b1;
                m_pc = m_pc + 16'd2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_en", 32'(imem_en), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_wr", 32'(imem_wr), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst            = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h8000 | 16'($urandom);
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        mem[3] = 16'h0000;
        model_reset();

        // reset values
        #1;
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst_valid0", 32'(instr_valid), 32'd0);
        chk("rst_en0", 32'(imem_en), 32'd0);
        chk("rst_halted0", 32'(halted), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // streaming with ready held high
        instr_ready = 1'b1;
        repeat (8) cycle();

        // backpressure: FIFO fills, PC holds, then drains with no gaps
        do_reset();
        instr_ready = 1'b0;
        repeat (5) cycle();
        chk("stall_addr", 32'(imem_addr), 32'h0004);
        chk("stall_en", 32'(imem_en), 32'd0);
        instr_ready = 1'b1;
        repeat (6) cycle();

        // redirect while full and popping
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0020;
        cycle();
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        repeat (3) cycle();
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0041;
        cycle();
        redirect_valid = 1'b0;
        chk("redir_valid", 32'(instr_valid), 32'd0);
        chk("redir_addr", 32'(imem_addr), 32'h0040);
        cycle();
        chk("redir_head_pc", 32'(instr_pc), 32'h0040);
        cycle();

        // HALT at address 6 stops fetch; redirect resumes
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0000;
        cycle();
        redirect_valid = 1'b0;
        acc8 = 0;
        repeat (25) cycle();
        chk("no_fetch_8", 32'(acc8), 32'd0);
        chk("halted_set", 32'(halted), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0010;
        cycle();
        redirect_valid = 1'b0;
        chk("halt_clear", 32'(halted), 32'd0);
        repeat (4) cycle();

        // address wrap
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk("wrap_pc0", 32'(instr_pc), 32'hFFFE);
        cycle();
        chk("wrap_pc1", 32'(instr_pc), 32'h0000);
        repeat (2) cycle();

        // reset mid-stream with FIFO holding the HALT word
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0000;
        cycle();
        redirect_valid = 1'b0;
        repeat (4) cycle();
        instr_ready = 1'b0;
        cycle();
        chk("pre_rst_valid", 32'(instr_valid), 32'd1);
        chk("pre_rst_halted", 32'(halted), 32'd1);
        do_reset();
        instr_ready = 1'b1;
        repeat (4) cycle();

        // randomized traffic
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        for (int n = 0; n < 600; n++) begin
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = 16'($urandom);
            cycle();
        end
        redirect_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
